// File: rtl/fb_inst_queue_pkg.sv
// Shared pipeline types for the frontend/backend boundary: default widths,
// the queued instruction record and a small popcount helper.
package fb_inst_queue_pkg;

    localparam int unsigned FETCH_WIDTH_DEF  = 2;
    localparam int unsigned DECODE_WIDTH_DEF = 2;
    localparam int unsigned DEPTH_DEF        = 16;
    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned INST_W_DEF       = 32;
    localparam int unsigned EXC_W_DEF        = 6;
    localparam int unsigned MAX_SLOTS        = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
        logic [EXC_W_DEF-1:0]  exc;
    } inst_queue_entry_t;

    function automatic logic [2:0] popcount(input logic [MAX_SLOTS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < int'(MAX_SLOTS); i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fb_inst_queue_ram.sv
// Instruction queue storage: multi-ported register file with synchronous
// writes and combinational reads; no reset, contents are don't-care when empty.
module fb_inst_queue_ram
    import fb_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned WR_PORTS = FETCH_WIDTH_DEF,
    parameter int unsigned RD_PORTS = DECODE_WIDTH_DEF,
    parameter int unsigned DATA_W   = ADDR_W_DEF + INST_W_DEF + EXC_W_DEF,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                         clk_i,
    input  logic [WR_PORTS-1:0]          we_i,
    input  logic [WR_PORTS*AW-1:0]       waddr_i,
    input  logic [WR_PORTS*DATA_W-1:0]   wdata_i,
    input  logic [RD_PORTS*AW-1:0]       raddr_i,
    output logic [RD_PORTS*DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write addresses are always distinct within a cycle, so port order is irrelevant.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < int'(WR_PORTS); w++) begin
            if (we_i[w]) begin
                mem_q[waddr_i[w*AW +: AW]] <= wdata_i[w*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar r = 0; r < int'(RD_PORTS); r++) begin : g_rd
        assign rdata_o[r*DATA_W +: DATA_W] = mem_q[raddr_i[r*AW +: AW]];
    end

endmodule

// File: rtl/fb_inst_queue.sv
// Fetch-to-decode instruction queue: compacts sparse fetch groups into a
// circular buffer and presents the oldest entries to decode in program order.
module fb_inst_queue
    import fb_inst_queue_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = FETCH_WIDTH_DEF,
    parameter int unsigned DECODE_WIDTH = DECODE_WIDTH_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned INST_W       = INST_W_DEF,
    parameter int unsigned EXC_W        = EXC_W_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           stall_i,
    input  logic [FETCH_WIDTH-1:0]         enq_valid_i,
    input  logic [FETCH_WIDTH*ADDR_W-1:0]  enq_pc_i,
    input  logic [FETCH_WIDTH*INST_W-1:0]  enq_inst_i,
    input  logic [FETCH_WIDTH*EXC_W-1:0]   enq_exc_i,
    output logic                           enq_ready_o,
    output logic [DECODE_WIDTH-1:0]        deq_valid_o,
    output logic [DECODE_WIDTH*ADDR_W-1:0] deq_pc_o,
    output logic [DECODE_WIDTH*INST_W-1:0] deq_inst_o,
    output logic [DECODE_WIDTH*EXC_W-1:0]  deq_exc_o,
    input  logic                           deq_ready_i,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = ADDR_W + INST_W + EXC_W;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq_fire, deq_fire;
    logic [2:0]    n_enq, n_deq, slot_off;

    logic [FETCH_WIDTH-1:0]     we;
    logic [FETCH_WIDTH*PW-1:0]  waddr;
    logic [FETCH_WIDTH*DW-1:0]  wdata;
    logic [DECODE_WIDTH*PW-1:0] raddr;
    logic [DECODE_WIDTH*DW-1:0] rdata;

    // Readiness looks only at the registered count so a full group is never split.
    assign enq_ready_o = (count_q <= CW'(DEPTH - FETCH_WIDTH));
    assign enq_fire    = enq_ready_o && (|enq_valid_i) && !flush_i;
    assign deq_fire    = deq_ready_i && !stall_i && !flush_i;
    assign count_o     = count_q;

    assign n_enq = enq_fire ? popcount(MAX_SLOTS'(enq_valid_i)) : 3'd0;
    assign n_deq = deq_fire ? popcount(MAX_SLOTS'(deq_valid_o)) : 3'd0;

    // Each valid slot lands at tail plus the number of valid slots before it.
    always_comb begin
        we       = '0;
        waddr    = '0;
        wdata    = '0;
        slot_off = 3'd0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            we[i]               = enq_fire && enq_valid_i[i];
            waddr[i*PW +: PW]   = tail_q + PW'(slot_off);
            wdata[i*DW +: DW]   = {enq_pc_i[i*ADDR_W +: ADDR_W],
                                   enq_inst_i[i*INST_W +: INST_W],
                                   enq_exc_i[i*EXC_W +: EXC_W]};
            slot_off            = slot_off + 3'(enq_valid_i[i]);
        end
    end

    always_comb begin
        deq_valid_o = '0;
        raddr       = '0;
        deq_pc_o    = '0;
        deq_inst_o  = '0;
        deq_exc_o   = '0;
        for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
            deq_valid_o[i]             = (count_q > CW'(i)) && !flush_i;
            raddr[i*PW +: PW]          = head_q + PW'(i);
            deq_pc_o[i*ADDR_W +: ADDR_W] = rdata[i*DW + INST_W + EXC_W +: ADDR_W];
            deq_inst_o[i*INST_W +: INST_W] = rdata[i*DW + EXC_W +: INST_W];
            deq_exc_o[i*EXC_W +: EXC_W]  = rdata[i*DW +: EXC_W];
        end
    end

    always_comb begin
        head_d  = head_q + PW'(n_deq);
        tail_d  = tail_q + PW'(n_enq);
        count_d = count_q + CW'(n_enq) - CW'(n_deq);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fb_inst_queue_ram #(
        .DEPTH    (DEPTH),
        .WR_PORTS (FETCH_WIDTH),
        .RD_PORTS (DECODE_WIDTH),
        .DATA_W   (DW),
        .AW       (PW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_fb_inst_queue.sv
// Scoreboard bench for fb_inst_queue: stimulus pushes accepted entries into a
// reference FIFO, a negedge monitor compares every presented output against it.
module tb_fb_inst_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  exc;
    } entry_t;

    logic        clk;
    logic        rst_ni;
    logic        flush, stall, deqReady;
    logic [1:0]  enqValid;
    logic [63:0] enqPc, enqInst;
    logic [11:0] enqExc;
    logic        enqReady;
    logic [1:0]  deqValid;
    logic [63:0] deqPc, deqInst;
    logic [11:0] deqExc;
    logic [4:0]  count;

    entry_t expQ[$];
    int     pendingEnq;
    int     testsRun;
    int     failCount;
    int     pushedTotal;
    int     poppedTotal;
    bit     monitorOn;
    logic [31:0] pcCounter;

    fb_inst_queue dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .stall_i     (stall),
        .enq_valid_i (enqValid),
        .enq_pc_i    (enqPc),
        .enq_inst_i  (enqInst),
        .enq_exc_i   (enqExc),
        .enq_ready_o (enqReady),
        .deq_valid_o (deqValid),
        .deq_pc_o    (deqPc),
        .deq_inst_o  (deqInst),
        .deq_exc_o   (deqExc),
        .deq_ready_i (deqReady),
        .count_o     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after the edge; accepted slots go to the scoreboard.
    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic doFlush, input logic doStall, input logic doDeqReady);
        entry_t e;
        logic [31:0] pcs [2];
        @(posedge clk);
        #1;
        pcs[0]   = pc0;
        pcs[1]   = pc1;
        enqValid = valid;
        flush    = doFlush;
        stall    = doStall;
        deqReady = doDeqReady;
        for (int s = 0; s < FW; s++) begin
            enqPc[s*32 +: 32]   = pcs[s];
            enqInst[s*32 +: 32] = $urandom;
            enqExc[s*6 +: 6]    = 6'($urandom_range(0, 63));
        end
        if (!doFlush && valid != 2'b00 && (DEPTH - expQ.size()) >= FW) begin
            for (int s = 0; s < FW; s++) begin
                if (valid[s]) begin
                    e.pc   = enqPc[s*32 +: 32];
                    e.inst = enqInst[s*32 +: 32];
                    e.exc  = enqExc[s*6 +: 6];
                    expQ.push_back(e);
                    pendingEnq++;
                    pushedTotal++;
                end
            end
        end
    endtask

    task automatic idle(input logic doDeqReady);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, doDeqReady);
    endtask

    task automatic nextGroup(input logic [1:0] valid, input logic doFlush, input logic doStall, input logic doDeqReady);
        applyStimulus(valid, pcCounter, pcCounter + 32'd4, doFlush, doStall, doDeqReady);
        pcCounter = pcCounter + 32'd8;
    endtask

    // Entries pushed this cycle become visible only after the next edge.
    always @(negedge clk) begin : monitor
        int visible;
        int nShow;
        logic [1:0] expValid;
        if (monitorOn) begin
            visible  = expQ.size() - pendingEnq;
            nShow    = (visible < DW) ? visible : DW;
            expValid = 2'b00;
            for (int i = 0; i < nShow; i++) expValid[i] = !flush;
            checkOutput("count", 64'(count), 64'(visible));
            checkOutput("enq_ready", 64'(enqReady), 64'((DEPTH - visible) >= FW));
            checkOutput("deq_valid", 64'(deqValid), 64'(expValid));
            if (!flush) begin
                for (int i = 0; i < nShow; i++) begin
                    checkOutput("deq_pc", 64'(deqPc[i*32 +: 32]), 64'(expQ[i].pc));
                    checkOutput("deq_inst", 64'(deqInst[i*32 +: 32]), 64'(expQ[i].inst));
                    checkOutput("deq_exc", 64'(deqExc[i*6 +: 6]), 64'(expQ[i].exc));
                end
            end
            if (flush) begin
                expQ.delete();
            end else if (deqReady && !stall) begin
                poppedTotal += $countones(deqValid);
                for (int i = 0; i < nShow; i++) void'(expQ.pop_front());
            end
        end
        pendingEnq = 0;
    end

    initial begin
        testsRun    = 0;
        failCount   = 0;
        pendingEnq  = 0;
        pushedTotal = 0;
        poppedTotal = 0;
        monitorOn   = 1'b0;
        pcCounter   = 32'h1000;
        rst_ni      = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        deqReady    = 1'b0;
        enqValid    = 2'b00;
        enqPc       = '0;
        enqInst     = '0;
        enqExc      = '0;

        @(posedge clk);
        #1;
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("reset_enq_ready", 64'(enqReady), 64'd1);
        @(negedge clk);
        rst_ni    = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] basic two-instruction pass-through");
        applyStimulus(2'b11, 32'h1c000000, 32'h1c000004, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("basic_deq_valid", 64'(deqValid), 64'd3);
        checkOutput("basic_pc0", 64'(deqPc[31:0]), 64'h1c000000);
        checkOutput("basic_pc1", 64'(deqPc[63:32]), 64'h1c000004);
        idle(1'b1);
        checkOutput("basic_count_after", 64'(count), 64'd0);

        $display("[TB] fill until enq_ready drops");
        for (int g = 0; g < 9; g++) nextGroup(2'b11, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("full_count", 64'(count), 64'd16);
        checkOutput("full_enq_ready", 64'(enqReady), 64'd0);
        for (int c = 0; c < 9; c++) idle(1'b1);
        checkOutput("drained_count", 64'(count), 64'd0);

        $display("[TB] sparse group, slot1 only");
        applyStimulus(2'b10, 32'hdead0000, 32'h00000100, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("sparse_count", 64'(count), 64'd1);
        checkOutput("sparse_pc", 64'(deqPc[31:0]), 64'h100);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] 40 continuous groups with random stall");
        pushedTotal = 0;
        poppedTotal = 0;
        for (int g = 0; g < 40; g++) nextGroup(2'b11, 1'b0, ($urandom_range(0, 2) == 0), 1'b1);
        for (int c = 0; c < 30; c++) idle(1'b1);
        checkOutput("stream_count", 64'(poppedTotal), 64'(pushedTotal));

        $display("[TB] flush with simultaneous enqueue and dequeue");
        for (int g = 0; g < 3; g++) nextGroup(2'b11, 1'b0, 1'b0, 1'b0);
        nextGroup(2'b01, 1'b0, 1'b0, 1'b0);
        nextGroup(2'b11, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("flush_enq_ready", 64'(enqReady), 64'd1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 300; c++) begin
            nextGroup(2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
        end
        for (int c = 0; c < 10; c++) idle(1'b1);

        $display("[TB] asynchronous reset mid-operation");
        nextGroup(2'b11, 1'b0, 1'b0, 1'b0);
        nextGroup(2'b11, 1'b0, 1'b0, 1'b0);
        nextGroup(2'b01, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("pre_reset_count", 64'(count), 64'd5);
        #2;
        monitorOn = 1'b0;
        rst_ni    = 1'b0;
        #1;
        checkOutput("async_reset_count", 64'(count), 64'd0);
        checkOutput("async_reset_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("async_reset_enq_ready", 64'(enqReady), 64'd1);
        expQ.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        monitorOn = 1'b1;
        applyStimulus(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/fb_inst_queue.md
# fb_inst_queue

Parametrised instruction queue that decouples the frontend fetch stage from the backend decode stage. Accepts up to FETCH_WIDTH fetched instructions per cycle and presents up to DECODE_WIDTH oldest instructions per cycle, in program order. Lets fetch run ahead of a stalled backend, and discards all contents on a branch flush. Sits inside the core between frontend_top and backend, driven by the same ctrl stall and branch_flush signals.

## Interface
- FETCH_WIDTH, 2, instructions offered by fetch per cycle (1..4)
- DECODE_WIDTH, 2, instructions presented to decode per cycle (1..4)
- DEPTH, 16, entries; power of two, ≥ 2×max(FETCH_WIDTH, DECODE_WIDTH)
- ADDR_W, 32, PC width; INST_W, 32, instruction width; EXC_W, 6, fetch exception code width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  branch flush; empties queue
- stall  in  1  backend stall; blocks dequeue
- enq_valid  in  FETCH_WIDTH  per-slot valid mask (any pattern)
- enq_pc / enq_inst / enq_exc  in  FETCH_WIDTH×ADDR_W / ×INST_W / ×EXC_W  slot payloads
- enq_ready  out  1  queue can take a full fetch group
- deq_valid  out  DECODE_WIDTH  thermometer mask of presented entries
- deq_pc / deq_inst / deq_exc  out  DECODE_WIDTH×ADDR_W / ×INST_W / ×EXC_W  oldest entries, slot 0 oldest
- deq_ready  in  1  decode takes every slot with deq_valid set
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: storage array, head pointer, tail pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), count register.
- enq_ready = (DEPTH − count) ≥ FETCH_WIDTH, from registered count only; same-cycle dequeue never raises it.
- Enqueue fires when enq_ready && |enq_valid && !flush. Valid slots compacted in slot order (e.g. mask 4'b1010 writes slot1 then slot3) to tail, tail+1, …; tail advances by popcount(enq_valid). Invalid slots ignored.
- deq_valid[i] = (count > i) && !flush. deq payload i = storage[head+i mod DEPTH].
- Dequeue fires when deq_ready && !stall && !flush; head advances by popcount(deq_valid), which equals min(count, DECODE_WIDTH).
- count_next = count + n_enq − n_deq. Simultaneous enqueue and dequeue are both honoured.
- Flush has priority over everything. Next cycle: head = tail = count = 0, so deq_valid = 0 and enq_ready = 1. No write or read takes effect in the flush cycle.
- Fetch exception codes are carried unmodified. The queue never inspects instruction contents.

## Timing
- Reset (asynchronous assert, synchronous release): head = tail = count = 0, deq_valid = 0, enq_ready = 1. Storage contents undefined.
- Enqueue-to-dequeue latency: 1 cycle. An entry written on edge N is visible on deq_* after edge N.
- Outputs depend combinationally only on registers and flush. No combinational path from enq_* or deq_ready/stall to any output.
- Full: count > DEPTH − FETCH_WIDTH drops enq_ready. Fetch must hold its group; the queue never partially accepts a group.
- Empty: deq_valid = 0, and deq_* payloads are don't-care.
- Wrap-around: pointer increments wrap modulo DEPTH. A group may straddle index DEPTH−1→0 on both the write and read side.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock.

## Structure
- In pipeline_types: inst_queue_entry_t {pc, inst, exc}, the default-width constants, and a popcount function shared with other stages.
- One sub-module, fb_inst_queue_ram: DEPTH-entry register file with FETCH_WIDTH write ports and DECODE_WIDTH combinational read ports. The compaction, pointer and count logic stays in the top.

## Test plan
- Reset then enqueue 2 instructions (pc 0x1c000000, 0x1c000004) with deq_ready=1, stall=0 -> next cycle deq_valid=2'b11 in order; following cycle count=0.
- Fill with deq_ready=0 (DEPTH=16, FETCH_WIDTH=2) -> enq_ready drops when count reaches 15 or more. Held group is not written; count stays 16 after the last accepted group.
- enq_valid=2'b10 with pc 0x100 in slot1 -> stored at tail alone; count+1; deq slot0 shows pc 0x100.
- Run 40 groups continuously with random stall -> pointers wrap more than twice; output PC stream matches input stream with no loss or duplication.
- Queue holds 7 entries; in one cycle assert flush with enq_valid=2'b11 and deq_ready=1 -> next cycle count=0, deq_valid=0, enq_ready=1, and neither group is recorded.
- Assert rst low between clock edges while count=5 -> count=0 and deq_valid=0 before the next edge.
